// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write-back path.
//   ADDR_W / DEPTH / ZERO_IDX : default register file geometry (32 regs, XZR at 31)
//   reg_addr_t, reg_onehot_t  : address and one-hot strobe vector types
//   port_idx_t                : write-port index, wide enough for the largest port count
//   psel_w()                  : width of a per-register port index, max(1, clog2(ports))
package regfile_pkg;

    localparam int ADDR_W    = 5;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int ZERO_IDX  = 31;
    localparam int MAX_PORTS = 4;

    typedef logic [ADDR_W-1:0]             reg_addr_t;
    typedef logic [DEPTH-1:0]              reg_onehot_t;
    typedef logic [$clog2(MAX_PORTS)-1:0]  port_idx_t;

    function automatic int psel_w(input int n_ports);
        return (n_ports <= 2) ? 1 : $clog2(n_ports);
    endfunction

endpackage

// File: rtl/regfile_write_decoder_decoder_n.sv
// decoder_n: combinational ADDR_W-to-DEPTH one-hot decoder with enable.
//   en   : when 0 the output is all zeros and addr is ignored (may be X)
//   addr : register address
//   y    : one-hot (en=1) or zero (en=0) strobe vector
module decoder_n #(
    parameter  int ADDR_W = 5,
    localparam int DEPTH  = 1 << ADDR_W
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  y
);

    always_comb begin
        y = '0;
        if (en) y[addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_write_decoder.sv
// regfile_write_decoder: registered multi-port write-select decoder for write-back.
//   clk, reset  : clock (rising edge), asynchronous active-high reset
//   flush       : loads zeros into the decode stage(s) instead of the inputs
//   wr_en       : per-port write request
//   wr_addr     : per-port address, port p at [p*ADDR_W +: ADDR_W]
//   wr_sel      : one-hot-or-zero write strobe per register
//   wr_src      : winning (lowest-index) port per register, 0 when not selected
//   collide     : >=2 enabled ports on the same writable register this cycle
//   zero_hit    : an enabled port targeted ZERO_IDX while it is masked
//   coll_cnt    : saturating count of collide pulses, cleared only by reset
// Build option: define REGFILE_WR_PIPE_EN to add a second output register
// stage (latency 2); all outputs, including coll_cnt, stay aligned.
module regfile_write_decoder #(
    parameter  int ADDR_W    = regfile_pkg::ADDR_W,
    parameter  int NUM_PORTS = 2,
    parameter  int ZERO_IDX  = regfile_pkg::ZERO_IDX,
    parameter  int MASK_ZERO = 1,
    parameter  int CNT_W     = 8,
    localparam int DEPTH     = 1 << ADDR_W,
    localparam int PSEL_W    = regfile_pkg::psel_w(NUM_PORTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_PORTS-1:0]      wr_en,
    input  logic [NUM_PORTS*ADDR_W-1:0] wr_addr,
    output logic [DEPTH-1:0]          wr_sel,
    output logic [DEPTH*PSEL_W-1:0]   wr_src,
    output logic                      collide,
    output logic                      zero_hit,
    output logic [CNT_W-1:0]          coll_cnt
);

    import regfile_pkg::*;

    typedef struct packed {
        logic [DEPTH-1:0]             sel;
        logic [DEPTH-1:0][PSEL_W-1:0] src;
        logic                         collide;
        logic                         zero_hit;
    } stage_t;

    // Per-port candidate strobes
    logic [NUM_PORTS-1:0][DEPTH-1:0] cand;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        decoder_n #(.ADDR_W(ADDR_W)) u_dec (
            .en   (wr_en[p]),
            .addr (wr_addr[p*ADDR_W +: ADDR_W]),
            .y    (cand[p])
        );
    end

    // Priority resolution: scanning ports upward, the first hit on a register
    // wins; any later hit on a writable register is a collision. Hits on a
    // masked ZERO_IDX only raise zero_hit.
    stage_t dec;

    always_comb begin
        logic found;
        logic masked;
        dec = '0;
        for (int r = 0; r < DEPTH; r++) begin
            masked = (MASK_ZERO != 0) && (r == ZERO_IDX);
            found  = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (cand[p][r]) begin
                    if (masked) begin
                        dec.zero_hit = 1'b1;
                    end else if (found) begin
                        dec.collide = 1'b1;
                    end else begin
                        found       = 1'b1;
                        dec.sel[r]  = 1'b1;
                        dec.src[r]  = PSEL_W'(p);
                    end
                end
            end
        end
    end

    // Stage 1
    stage_t s1_d, s1_q;
    stage_t stage_out_next;  // value the output stage loads at the next edge
    stage_t stage_out;       // current output stage

    always_comb s1_d = flush ? '0 : dec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) s1_q <= '0;
        else       s1_q <= s1_d;
    end

`ifdef REGFILE_WR_PIPE_EN
    // Stage 2; flush clears it too so nothing in flight survives a flush.
    stage_t s2_d, s2_q;

    always_comb s2_d = flush ? '0 : s1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) s2_q <= '0;
        else       s2_q <= s2_d;
    end

    assign stage_out_next = s2_d;
    assign stage_out      = s2_q;
`else
    assign stage_out_next = s1_d;
    assign stage_out      = s1_q;
`endif

    // Counter advances with the collide bit entering the output stage, so it
    // stays aligned with collide and never counts flushed requests.
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (stage_out_next.collide && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign wr_sel   = stage_out.sel;
    assign wr_src   = stage_out.src;
    assign collide  = stage_out.collide;
    assign zero_hit = stage_out.zero_hit;
    assign coll_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_decoder.sv
module tb_regfile_write_decoder;

    import regfile_pkg::*;

`ifdef REGFILE_WR_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        flush   = 1'b0;
    logic [1:0]  wr_en   = '0;
    logic [9:0]  wr_addr = '0;

    reg_onehot_t sel_a, sel_b;
    logic [31:0] src_a, src_b;
    logic        col_a, col_b, zh_a, zh_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    // Default build: masked XZR, 8-bit counter
    regfile_write_decoder dut_a (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_sel(sel_a), .wr_src(src_a), .collide(col_a), .zero_hit(zh_a), .coll_cnt(cnt_a)
    );

    // Writable register 31, 2-bit counter (saturation at 3)
    regfile_write_decoder #(.MASK_ZERO(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_sel(sel_b), .wr_src(src_b), .collide(col_b), .zero_hit(zh_b), .coll_cnt(cnt_b)
    );

    typedef struct packed {
        logic [31:0] sel;
        logic [31:0] src;
        logic        col;
        logic        zh;
    } exp_t;

    exp_t ea [2];
    exp_t eb [2];
    int   ca, cb;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: let ports write from highest index down so the lowest index
    // overwrites and wins; a second write to an already-written register is a
    // collision. Masked XZR hits only flag zero_hit.
    function automatic exp_t model(input bit mask, input logic [1:0] en, input logic [9:0] addr);
        exp_t e;
        int   a;
        e = '0;
        for (int p = 1; p >= 0; p--) begin
            if (en[p]) begin
                a = int'(addr[p*5 +: 5]);
                if (mask && a == 31) begin
                    e.zh = 1'b1;
                end else begin
                    if (e.sel[a]) e.col = 1'b1;
                    e.sel[a] = 1'b1;
                    e.src[a] = 1'(p);
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_model();
        ea[0] = '0; ea[1] = '0;
        eb[0] = '0; eb[1] = '0;
        ca = 0; cb = 0;
    endtask

    // One clock: model follows the DUTs at the edge, inputs change 2 time units later.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (flush) begin
                ea[0] = '0; ea[1] = '0;
                eb[0] = '0; eb[1] = '0;
            end else begin
                ea[1] = ea[0]; ea[0] = model(1'b1, wr_en, wr_addr);
                eb[1] = eb[0]; eb[0] = model(1'b0, wr_en, wr_addr);
            end
            if (ea[LAT-1].col && ca < 255) ca++;
            if (eb[LAT-1].col && cb < 3)   cb++;
        end
        #2;
    endtask

    task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                         input logic fl);
        wr_en   = en;
        wr_addr = {a1, a0};
        flush   = fl;
        tick();
    endtask

    task automatic idle();
        drive(2'b00, 5'($urandom), 5'($urandom), 1'b0);
    endtask

    task automatic settle();
        repeat (LAT - 1) idle();
    endtask

    function automatic logic [4:0] pick();
        case ($urandom_range(3))
            0:       return 5'd7;
            1:       return 5'd9;
            2:       return 5'd31;
            default: return 5'($urandom);
        endcase
    endfunction

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("sel_a",  64'(sel_a), 64'(ea[LAT-1].sel));
        chk("src_a",  64'(src_a), 64'(ea[LAT-1].src));
        chk("col_a",  64'(col_a), 64'(ea[LAT-1].col));
        chk("zh_a",   64'(zh_a),  64'(ea[LAT-1].zh));
        chk("cnt_a",  64'(cnt_a), 64'(ca));
        chk("sel_b",  64'(sel_b), 64'(eb[LAT-1].sel));
        chk("src_b",  64'(src_b), 64'(eb[LAT-1].src));
        chk("col_b",  64'(col_b), 64'(eb[LAT-1].col));
        chk("zh_b",   64'(zh_b),  64'(eb[LAT-1].zh));
        chk("cnt_b",  64'(cnt_b), 64'(cb));
    end

    initial begin
        clr_model();

        // Reset held with random inputs
        repeat (4) drive(2'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
        chk("rst_sel",  64'(sel_a), 64'h0);
        chk("rst_cnt",  64'(cnt_a), 64'h0);
        reset = 1'b0;
        repeat (3) idle();
        chk("idle_sel", 64'(sel_a), 64'h0);

        // Single write
        drive(2'b01, 5'd5, 5'($urandom), 1'b0);
        settle();
        chk("single_sel", 64'(sel_a), 64'h20);
        chk("single_src", 64'(src_a), 64'h0);
        chk("single_col", 64'(col_a), 64'h0);

        // Two distinct addresses
        drive(2'b11, 5'd3, 5'd9, 1'b0);
        settle();
        chk("dual_sel", 64'(sel_a), 64'h208);
        chk("dual_src", 64'(src_a), 64'h200);

        // Three back-to-back collisions, then two more to saturate dut_b
        repeat (3) drive(2'b11, 5'd7, 5'd7, 1'b0);
        settle();
        chk("coll_sel",   64'(sel_a), 64'h80);
        chk("coll_src",   64'(src_a), 64'h0);
        chk("coll_pulse", 64'(col_a), 64'h1);
        chk("coll_cnt3",  64'(cnt_a), 64'd3);
        chk("coll_cntb3", 64'(cnt_b), 64'd3);
        repeat (2) drive(2'b11, 5'd7, 5'd7, 1'b0);
        settle();
        chk("coll_cnt5",  64'(cnt_a), 64'd5);
        chk("coll_sat",   64'(cnt_b), 64'd3);

        // Both ports on register 31
        drive(2'b11, 5'd31, 5'd31, 1'b0);
        settle();
        chk("zero_sel_a", 64'(sel_a), 64'h0);
        chk("zero_hit_a", 64'(zh_a),  64'h1);
        chk("zero_col_a", 64'(col_a), 64'h0);
        chk("zero_cnt_a", 64'(cnt_a), 64'd5);
        chk("zero_sel_b", 64'(sel_b), 64'h8000_0000);
        chk("zero_col_b", 64'(col_b), 64'h1);
        chk("zero_hit_b", 64'(zh_b),  64'h0);

        // Flushed collision: nothing visible, counter untouched
        drive(2'b11, 5'd7, 5'd7, 1'b1);
        settle();
        chk("flush_sel", 64'(sel_a), 64'h0);
        chk("flush_col", 64'(col_a), 64'h0);
        chk("flush_cnt", 64'(cnt_a), 64'd5);

        // Collision followed by a flush: with two stages it is still in flight and dropped
        drive(2'b11, 5'd7, 5'd7, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 1'b1);
        settle();
        chk("flush_inflight_cnt", 64'(cnt_a), (LAT == 1) ? 64'd6 : 64'd5);
        chk("flush_inflight_sel", 64'(sel_a), 64'h0);

        // Asynchronous reset mid-cycle with a request in flight
        drive(2'b11, 5'd7, 5'd7, 1'b0);
        #1 reset = 1'b1;
        clr_model();
        #1;
        chk("async_sel_a", 64'(sel_a), 64'h0);
        chk("async_col_a", 64'(col_a), 64'h0);
        chk("async_cnt_a", 64'(cnt_a), 64'h0);
        chk("async_cnt_b", 64'(cnt_b), 64'h0);
        tick();
        reset = 1'b0;
        repeat (2) idle();

        // Mixed traffic from a small address set to provoke collisions and XZR hits
        for (int i = 0; i < 60; i++)
            drive(2'($urandom), pick(), pick(), ($urandom_range(7) == 0));
        repeat (LAT) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
